// File: rtl/uart_pkg.sv
// Shared UART frame definitions: state encodings and oversampling ratio.
// The UART receiver imports the same package.
package uart_pkg;

  localparam int unsigned OS_TICKS = 16;
  localparam int unsigned S_W      = 6;
  localparam int unsigned N_W      = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start, DataBits data bits LSB first, optional even parity, stop.
// Define UART_TX_PARITY_EN to insert the even-parity bit after the data bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DataBits = 8,
  parameter int unsigned SbTicks  = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                s_tick_i,
  input  logic                tx_start_i,
  input  logic [DataBits-1:0] din_i,
  output logic                tx_busy_o,
  output logic                tx_done_tick_o,
  output logic                tx_o
);

  tx_state_e           state_q, state_d;
  logic [S_W-1:0]      s_q, s_d;
  logic [N_W-1:0]      n_q, n_d;
  logic [DataBits-1:0] b_q, b_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic                par_q, par_d;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state, counters and shift register; line level follows the next state.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (tx_start_i) begin
          b_d     = din_i;
          s_d     = '0;
          state_d = ST_START;
`ifdef UART_TX_PARITY_EN
          par_d   = ^din_i;
`endif
        end
      end
      ST_START: begin
        if (s_tick_i) begin
          if (s_q == S_W'(OS_TICKS - 1)) begin
            s_d     = '0;
            n_d     = '0;
            state_d = ST_DATA;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (s_tick_i) begin
          if (s_q == S_W'(OS_TICKS - 1)) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == N_W'(DataBits - 1)) begin
`ifdef UART_TX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              n_d = n_q + N_W'(1);
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (s_tick_i) begin
          if (s_q == S_W'(OS_TICKS - 1)) begin
            s_d     = '0;
            state_d = ST_STOP;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
`endif
      ST_STOP: begin
        if (s_tick_i) begin
          if (s_q == S_W'(SbTicks - 1)) begin
            s_d     = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    tx_d = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = par_d;
`endif
      default:   tx_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign tx_o           = tx_q;
  assign tx_busy_o      = busy_q;
  assign tx_done_tick_o = done_q;

endmodule
